// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request, response and memory-port signals of the IM/DM memory arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  im_req;
    logic [ADDR_WIDTH-1:0] im_addr;
    logic [DATA_WIDTH-1:0] im_rdata;
    logic                  im_ack;
    logic                  dm_read;
    logic                  dm_write;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_ack;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;
    logic                  cpu_stall;
    logic                  bus_error;

    // Requester/memory environment side
    modport master (
        output im_req, im_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ready,
        input  im_rdata, im_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
               cpu_stall, bus_error
    );

    // Arbiter side
    modport slave (
        input  im_req, im_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ready,
        output im_rdata, im_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
               cpu_stall, bus_error
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between instruction fetch and data load/store
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input logic              clock,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACC_IM,
        ACC_DM
    } state_t;

    // Abort fires on the TIMEOUT-th consecutive cycle without mem_ready.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t                state;
    logic                  last_dm;
    logic [7:0]            wait_cnt;
    logic                  en_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] im_rdata_q;
    logic [DATA_WIDTH-1:0] dm_rdata_q;
    logic                  im_ack_q;
    logic                  dm_ack_q;
    logic                  err_q;

    logic                  dm_req;
    logic                  im_pend;
    logic                  dm_pend;

    // A side acked this cycle is masked so its still-high request is not re-granted.
    assign dm_req  = bus.dm_read | bus.dm_write;
    assign im_pend = bus.im_req & ~im_ack_q;
    assign dm_pend = dm_req & ~dm_ack_q;

    assign bus.cpu_stall = im_pend | dm_pend;
    assign bus.mem_en    = en_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.im_rdata  = im_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.im_ack    = im_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.bus_error = err_q;

    // Arbitration FSM: grant in IDLE, hold the memory handshake, complete or time out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_dm    <= 1'b1;
            wait_cnt   <= '0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            im_rdata_q <= '0;
            dm_rdata_q <= '0;
            im_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            im_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (im_pend && (!dm_pend || last_dm)) begin
                        addr_q   <= bus.im_addr;
                        wdata_q  <= '0;
                        we_q     <= 1'b0;
                        en_q     <= 1'b1;
                        last_dm  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= ACC_IM;
                    end else if (dm_pend) begin
                        addr_q   <= bus.dm_addr;
                        wdata_q  <= bus.dm_wdata;
                        we_q     <= bus.dm_write;
                        en_q     <= 1'b1;
                        last_dm  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= ACC_DM;
                    end
                end
                ACC_IM, ACC_DM: begin
                    if (bus.mem_ready) begin
                        en_q  <= 1'b0;
                        state <= IDLE;
                        if (state == ACC_IM) begin
                            im_rdata_q <= bus.mem_rdata;
                            im_ack_q   <= 1'b1;
                        end else begin
                            if (!we_q) begin
                                dm_rdata_q <= bus.mem_rdata;
                            end
                            dm_ack_q <= 1'b1;
                        end
                    end else if (wait_cnt == LAST_WAIT) begin
                        en_q  <= 1'b0;
                        err_q <= 1'b1;
                        state <= IDLE;
                        if (state == ACC_IM) begin
                            im_rdata_q <= '0;
                            im_ack_q   <= 1'b1;
                        end else begin
                            dm_rdata_q <= '0;
                            dm_ack_q   <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    en_q  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
